ysyx_25040111_lsu_arb: RTL and testbench

Two-requester memory arbiter placed directly upstream of the core's LSU. It replaces the combinational fetch/data mux in the core top level. It accepts one-cycle request pulses from the instruction-fetch path (IFU) and the execute/data path, and buffers one pending request per requester so that no request is lost. It issues exactly one request at a time to the LSU and routes the LSU completion pulse and read data back to the requester that owns the transaction.

---
 rtl/ysyx_25040111_lsu_arb.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ysyx_25040111_lsu_arb.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25040111_lsu_arb.sv
// ysyx_25040111_lsu_arb
// Two-requester (fetch / execute) arbiter in front of the LSU. Each requester
// owns a one-entry pending slot. The arbiter issues one transaction at a time
// as a single-cycle lsu_ready pulse with a registered command, then routes the
// completion pulse and read data back to the owning requester.
//
// Build option: define YSYX_25040111_ARB_RR_EN for round-robin arbitration.
// Without it, ex has fixed priority over if and no pointer register exists.
module ysyx_25040111_lsu_arb (
  input  logic        clock,
  input  logic        reset,
  // fetch requester
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ok,
  // execute / data requester
  input  logic        ex_req,
  input  logic        ex_wen,
  input  logic        ex_ren,
  input  logic        ex_sign,
  input  logic [1:0]  ex_mask,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  output logic [31:0] ex_rdata,
  output logic        ex_ok,
  // LSU side
  output logic        lsu_ready,
  output logic        lsu_wen,
  output logic        lsu_ren,
  output logic        lsu_sign,
  output logic [1:0]  lsu_mask,
  output logic [31:0] lsu_addr,
  output logic [31:0] lsu_wdata,
  input  logic [31:0] lsu_rdata,
  input  logic        lsu_valid,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        owner_ex_q, owner_ex_d;   // 1: ex owns the LSU, 0: fetch owns it

  // fetch pending slot (command fields are implied: load word, unsigned)
  logic        if_v_q, if_v_d;
  logic [31:0] if_addr_q, if_addr_d;

  // execute pending slot
  logic        ex_v_q, ex_v_d;
  logic        ex_wen_q, ex_wen_d;
  logic        ex_ren_q, ex_ren_d;
  logic        ex_sign_q, ex_sign_d;
  logic [1:0]  ex_mask_q, ex_mask_d;
  logic [31:0] ex_addr_q, ex_addr_d;
  logic [31:0] ex_wdata_q, ex_wdata_d;

  // registered LSU command
  logic        lsu_wen_q, lsu_wen_d;
  logic        lsu_ren_q, lsu_ren_d;
  logic        lsu_sign_q, lsu_sign_d;
  logic [1:0]  lsu_mask_q, lsu_mask_d;
  logic [31:0] lsu_addr_q, lsu_addr_d;
  logic [31:0] lsu_wdata_q, lsu_wdata_d;

  // responses
  logic        if_ok_q, if_ok_d;
  logic        ex_ok_q, ex_ok_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] ex_rdata_q, ex_rdata_d;

`ifdef YSYX_25040111_ARB_RR_EN
  logic        last_ex_q, last_ex_d;     // 1: ex was served last
`endif

  // A requester owns the LSU from its grant until its completion edge.
  logic if_own, ex_own;
  logic if_acc, ex_acc;
  logic if_elig, ex_elig;
  logic grant_ex;

  assign if_own = (state_q != S_IDLE) && !owner_ex_q;
  assign ex_own = (state_q != S_IDLE) &&  owner_ex_q;

  // A req into a full slot, or from the current owner, is dropped.
  assign if_acc = if_req && !if_v_q && !if_own;
  assign ex_acc = ex_req && !ex_v_q && !ex_own;

  // A freshly accepted req may be granted on the same edge it is captured.
  assign if_elig = if_v_q || if_acc;
  assign ex_elig = ex_v_q || ex_acc;

`ifdef YSYX_25040111_ARB_RR_EN
  assign grant_ex = ex_elig && (!if_elig || !last_ex_q);
`else
  assign grant_ex = ex_elig;
`endif

  // Next-state, slot bookkeeping, grant and completion routing.
  // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    owner_ex_d  = owner_ex_q;
    if_v_d      = if_v_q;
    if_addr_d   = if_addr_q;
    ex_v_d      = ex_v_q;
    ex_wen_d    = ex_wen_q;
    ex_ren_d    = ex_ren_q;
    ex_sign_d   = ex_sign_q;
    ex_mask_d   = ex_mask_q;
    ex_addr_d   = ex_addr_q;
    ex_wdata_d  = ex_wdata_q;
    lsu_wen_d   = lsu_wen_q;
    lsu_ren_d   = lsu_ren_q;
    lsu_sign_d  = lsu_sign_q;
    lsu_mask_d  = lsu_mask_q;
    lsu_addr_d  = lsu_addr_q;
    lsu_wdata_d = lsu_wdata_q;
    if_ok_d     = 1'b0;
    ex_ok_d     = 1'b0;
    if_rdata_d  = if_rdata_q;
    ex_rdata_d  = ex_rdata_q;
`ifdef YSYX_25040111_ARB_RR_EN
    last_ex_d   = last_ex_q;
`endif

    if (if_acc) begin
      if_v_d    = 1'b1;
      if_addr_d = if_addr;
    end
    if (ex_acc) begin
      ex_v_d     = 1'b1;
      ex_wen_d   = ex_wen;
      ex_ren_d   = ex_ren;
      ex_sign_d  = ex_sign;
      ex_mask_d  = ex_mask;
      ex_addr_d  = ex_addr;
      ex_wdata_d = ex_wdata;
    end

    unique case (state_q)
      S_IDLE: begin
        if (if_elig || ex_elig) begin
          state_d    = S_ISSUE;
          owner_ex_d = grant_ex;
`ifdef YSYX_25040111_ARB_RR_EN
          last_ex_d  = grant_ex;
`endif
          if (grant_ex) begin
            // Slot is cleared even if it was loaded this very cycle.
            ex_v_d      = 1'b0;
            lsu_wen_d   = ex_v_q ? ex_wen_q   : ex_wen;
            lsu_ren_d   = ex_v_q ? ex_ren_q   : ex_ren;
            lsu_sign_d  = ex_v_q ? ex_sign_q  : ex_sign;
            lsu_mask_d  = ex_v_q ? ex_mask_q  : ex_mask;
            lsu_addr_d  = ex_v_q ? ex_addr_q  : ex_addr;
            lsu_wdata_d = ex_v_q ? ex_wdata_q : ex_wdata;
          end else begin
            if_v_d      = 1'b0;
            lsu_wen_d   = 1'b0;
            lsu_ren_d   = 1'b1;
            lsu_sign_d  = 1'b0;
            lsu_mask_d  = 2'b11;
            lsu_addr_d  = if_v_q ? if_addr_q : if_addr;
            lsu_wdata_d = 32'd0;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (lsu_valid) begin
          state_d = S_IDLE;
          if (owner_ex_q) begin
            ex_ok_d    = 1'b1;
            ex_rdata_d = lsu_rdata;
          end else begin
            if_ok_d    = 1'b1;
            if_rdata_d = lsu_rdata;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  // NOTE: non-blocking (<=) here so every flop samples pre-edge values.
  // NOTE: slot payloads are reset too, keeping lsu_* and rdata at defined zeros.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_ex_q  <= 1'b0;
      if_v_q      <= 1'b0;
      if_addr_q   <= 32'd0;
      ex_v_q      <= 1'b0;
      ex_wen_q    <= 1'b0;
      ex_ren_q    <= 1'b0;
      ex_sign_q   <= 1'b0;
      ex_mask_q   <= 2'b00;
      ex_addr_q   <= 32'd0;
      ex_wdata_q  <= 32'd0;
      lsu_wen_q   <= 1'b0;
      lsu_ren_q   <= 1'b0;
      lsu_sign_q  <= 1'b0;
      lsu_mask_q  <= 2'b00;
      lsu_addr_q  <= 32'd0;
      lsu_wdata_q <= 32'd0;
      if_ok_q     <= 1'b0;
      ex_ok_q     <= 1'b0;
      if_rdata_q  <= 32'd0;
      ex_rdata_q  <= 32'd0;
`ifdef YSYX_25040111_ARB_RR_EN
      last_ex_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_ex_q  <= owner_ex_d;
      if_v_q      <= if_v_d;
      if_addr_q   <= if_addr_d;
      ex_v_q      <= ex_v_d;
      ex_wen_q    <= ex_wen_d;
      ex_ren_q    <= ex_ren_d;
      ex_sign_q   <= ex_sign_d;
      ex_mask_q   <= ex_mask_d;
      ex_addr_q   <= ex_addr_d;
      ex_wdata_q  <= ex_wdata_d;
      lsu_wen_q   <= lsu_wen_d;
      lsu_ren_q   <= lsu_ren_d;
      lsu_sign_q  <= lsu_sign_d;
      lsu_mask_q  <= lsu_mask_d;
      lsu_addr_q  <= lsu_addr_d;
      lsu_wdata_q <= lsu_wdata_d;
      if_ok_q     <= if_ok_d;
      ex_ok_q     <= ex_ok_d;
      if_rdata_q  <= if_rdata_d;
      ex_rdata_q  <= ex_rdata_d;
`ifdef YSYX_25040111_ARB_RR_EN
      last_ex_q   <= last_ex_d;
`endif
    end
  end

  assign lsu_ready = (state_q == S_ISSUE);
  assign busy      = (state_q != S_IDLE);
  assign lsu_wen   = lsu_wen_q;
  assign lsu_ren   = lsu_ren_q;
  assign lsu_sign  = lsu_sign_q;
  assign lsu_mask  = lsu_mask_q;
  assign lsu_addr  = lsu_addr_q;
  assign lsu_wdata = lsu_wdata_q;
  assign if_ok     = if_ok_q;
  assign ex_ok     = ex_ok_q;
  assign if_rdata  = if_rdata_q;
  assign ex_rdata  = ex_rdata_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu_arb.sv
// Testbench for ysyx_25040111_lsu_arb: scoreboard-based. Drivers push accepted
// requests into per-requester queues; a monitor predicts each grant from the
// arbitration rule, checks the issued command, its stability and busy, and
// checks every completion pulse against what the LSU model returned.
module tb_ysyx_25040111_lsu_arb;

  typedef struct packed {
    logic        is_ex;
    logic        wen;
    logic        ren;
    logic        sign;
    logic [1:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct packed {
    logic        is_ex;
    logic [31:0] data;
    int          cyc;
  } comp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ok;
  logic        ex_req = 1'b0;
  logic        ex_wen = 1'b0, ex_ren = 1'b0, ex_sign = 1'b0;
  logic [1:0]  ex_mask = '0;
  logic [31:0] ex_addr = '0, ex_wdata = '0;
  logic [31:0] ex_rdata;
  logic        ex_ok;
  logic        lsu_ready, lsu_wen, lsu_ren, lsu_sign;
  logic [1:0]  lsu_mask;
  logic [31:0] lsu_addr, lsu_wdata;
  logic [31:0] lsu_rdata = '0;
  logic        lsu_valid = 1'b0;
  logic        busy;

  ysyx_25040111_lsu_arb dut (
    .clock(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ok(if_ok),
    .ex_req(ex_req), .ex_wen(ex_wen), .ex_ren(ex_ren), .ex_sign(ex_sign),
    .ex_mask(ex_mask), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_rdata(ex_rdata), .ex_ok(ex_ok),
    .lsu_ready(lsu_ready), .lsu_wen(lsu_wen), .lsu_ren(lsu_ren),
    .lsu_sign(lsu_sign), .lsu_mask(lsu_mask), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_rdata(lsu_rdata), .lsu_valid(lsu_valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- reference model state ----------------
  cmd_t  if_q[$];
  cmd_t  ex_q[$];
  comp_t comp_q[$];
  logic [31:0] rdata_q[$];     // forced LSU read data, else random
  bit    grant_log[$];         // 1 = ex granted
  bit    owner_valid = 0;
  bit    owner_ex = 0;
  int    issue_cyc = 0;
  cmd_t  cur_cmd;
  int    ready_cnt = 0, last_ready_cyc = 0, last_valid_cyc = 0;
  int    if_done = 0, ex_done = 0;
`ifdef YSYX_25040111_ARB_RR_EN
  bit    last_was_if = 1;
`endif

  // LSU model control
  bit    resp_en = 1;
  int    resp_fixed = -1;
  int    stray_cnt = 0;

  // ---------------- LSU responder ----------------
  initial begin
    int stray_done = 0;
    forever begin
      @(negedge clk);
      if (stray_cnt != stray_done) begin
        stray_done++;
        @(posedge clk); #1;
        lsu_valid = 1'b1; lsu_rdata = $urandom;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
      end else if (lsu_ready && resp_en && !reset) begin
        int d;
        d = (resp_fixed >= 0) ? resp_fixed : int'($urandom_range(0, 3));
        repeat (1 + d) @(posedge clk);
        #1;
        lsu_valid = 1'b1;
        lsu_rdata = (rdata_q.size() > 0) ? rdata_q.pop_front() : $urandom;
        @(posedge clk); #1;
        lsu_valid = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    cmd_t  e;
    comp_t c;
    bit    pick_ex;
    forever begin
      @(negedge clk);
      if (reset) begin
        if_q.delete(); ex_q.delete(); comp_q.delete();
        owner_valid = 0;
`ifdef YSYX_25040111_ARB_RR_EN
        last_was_if = 1;
`endif
      end else begin
        // completions: one pulse for the owner exactly one cycle after lsu_valid
        if (comp_q.size() > 0 && comp_q[0].cyc <= cyc) begin
          c = comp_q.pop_front();
          check("ok_owner", {30'd0, if_ok, ex_ok}, c.is_ex ? 32'd1 : 32'd2);
          check("ok_cycle", cyc, c.cyc);
          check(c.is_ex ? "ex_rdata" : "if_rdata", c.is_ex ? ex_rdata : if_rdata, c.data);
        end else if (if_ok || ex_ok) begin
          check("unexpected_ok", {30'd0, if_ok, ex_ok}, 32'd0);
        end

        // issue: predict owner from the pending set and the arbitration rule
        if (lsu_ready) begin
          check("ready_while_busy", {31'd0, owner_valid}, 32'd0);
          if (if_q.size() == 0 && ex_q.size() == 0) begin
            check("issue_without_request", {31'd0, lsu_ready}, 32'd0);
          end else begin
`ifdef YSYX_25040111_ARB_RR_EN
            if (if_q.size() > 0 && ex_q.size() > 0) pick_ex = last_was_if;
            else pick_ex = (ex_q.size() > 0);
            last_was_if = !pick_ex;
`else
            pick_ex = (ex_q.size() > 0);
`endif
            e = pick_ex ? ex_q.pop_front() : if_q.pop_front();
            check("lsu_cmd", {27'd0, lsu_wen, lsu_ren, lsu_sign, lsu_mask},
                  {27'd0, e.wen, e.ren, e.sign, e.mask});
            check("lsu_addr", lsu_addr, e.addr);
            if (e.is_ex) check("lsu_wdata", lsu_wdata, e.wdata);
            owner_valid = 1; owner_ex = pick_ex; issue_cyc = cyc; cur_cmd = e;
            ready_cnt++; last_ready_cyc = cyc;
            grant_log.push_back(pick_ex);
          end
        end

        check("busy", {31'd0, busy}, {31'd0, owner_valid});

        // command must hold stable through WAIT
        if (owner_valid && cyc > issue_cyc) begin
          check("hold_cmd", {27'd0, lsu_wen, lsu_ren, lsu_sign, lsu_mask},
                {27'd0, cur_cmd.wen, cur_cmd.ren, cur_cmd.sign, cur_cmd.mask});
          check("hold_addr", lsu_addr, cur_cmd.addr);
        end

        // completion accepted only while waiting
        if (lsu_valid && owner_valid && cyc > issue_cyc) begin
          c.is_ex = owner_ex; c.data = lsu_rdata; c.cyc = cyc + 1;
          comp_q.push_back(c);
          owner_valid = 0;
          last_valid_cyc = cyc;
          if (owner_ex) ex_done++; else if_done++;
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_if(input logic [31:0] a, input bit model, output int drive_cyc);
    cmd_t e;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = a; drive_cyc = cyc;
    @(posedge clk);
    if (model) begin
      e = '{is_ex: 1'b0, wen: 1'b0, ren: 1'b1, sign: 1'b0, mask: 2'b11, addr: a, wdata: 32'd0};
      if_q.push_back(e);
    end
    #1;
    if_req = 1'b0; if_addr = $urandom;
  endtask

  task automatic send_ex(input cmd_t e, input bit model);
    @(posedge clk); #1;
    ex_req = 1'b1; ex_wen = e.wen; ex_ren = e.ren; ex_sign = e.sign;
    ex_mask = e.mask; ex_addr = e.addr; ex_wdata = e.wdata;
    @(posedge clk);
    if (model) ex_q.push_back(e);
    #1;
    ex_req = 1'b0; ex_addr = $urandom; ex_wdata = $urandom;
    ex_wen = 1'b0; ex_ren = 1'b0; ex_mask = 2'b00;
  endtask

  function automatic cmd_t rand_ex();
    cmd_t e;
    int   m;
    e.is_ex = 1'b1;
    e.wen   = 1'($urandom_range(0, 1));
    e.ren   = !e.wen;
    e.sign  = e.ren ? 1'($urandom_range(0, 1)) : 1'b0;
    m       = $urandom_range(0, 2);
    e.mask  = (m == 2) ? 2'b11 : 2'(m);
    e.addr  = $urandom;
    e.wdata = $urandom;
    return e;
  endfunction

  task automatic wait_ready(input int n0);
    int t;
    for (t = 0; t < 100 && ready_cnt <= n0; t++) @(negedge clk);
    if (ready_cnt <= n0) check("ready_timeout", ready_cnt, n0 + 1);
  endtask

  task automatic wait_idle();
    int t;
    for (t = 0; t < 300 && (if_q.size() || ex_q.size() || owner_valid || comp_q.size()); t++)
      @(negedge clk);
    check("idle_timeout", if_q.size() + ex_q.size() + comp_q.size() + int'(owner_valid), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1; reset = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   dc, n0, d0;
    cmd_t e;

    repeat (3) @(posedge clk);
    #1; reset = 1'b0;
    @(negedge clk);
    check("rst_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ok", {30'd0, if_ok, ex_ok}, 32'd0);
    check("rst_lsu_cmd", {27'd0, lsu_wen, lsu_ren, lsu_sign, lsu_mask}, 32'd0);
    check("rst_lsu_addr", lsu_addr, 32'd0);
    check("rst_lsu_wdata", lsu_wdata, 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_ex_rdata", ex_rdata, 32'd0);

    // simultaneous requests straight from reset: ex first in both builds
    grant_log.delete();
    e = '{is_ex: 1'b1, wen: 1'b0, ren: 1'b1, sign: 1'b1, mask: 2'b01, addr: 32'h8000_0010, wdata: 32'd0};
    fork
      send_if(32'h3000_0040, 1, dc);
      send_ex(e, 1);
    join
    wait_idle();
    check("sim_grants", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("sim_first_ex", {31'd0, grant_log[0]}, 32'd1);
      check("sim_second_if", {31'd0, grant_log[1]}, 32'd0);
    end

    // single fetch with known instruction word and one-cycle issue latency
    rdata_q.push_back(32'h0000_0413);
    resp_fixed = 2;
    n0 = ready_cnt;
    send_if(32'h3000_0000, 1, dc);
    wait_ready(n0);
    check("fetch_issue_latency", last_ready_cyc - dc, 1);
    wait_idle();
    check("fetch_rdata", if_rdata, 32'h0000_0413);

    // byte store
    e = '{is_ex: 1'b1, wen: 1'b1, ren: 1'b0, sign: 1'b0, mask: 2'b00, addr: 32'h8000_0004, wdata: 32'h0000_00AB};
    send_ex(e, 1);
    wait_idle();

    // pending buffering plus dropped protocol-error requests
    resp_fixed = 3;
    e = rand_ex();
    n0 = ready_cnt;
    send_ex(e, 1);
    wait_ready(n0);
    send_if(32'h3000_0100, 1, dc);     // lands in WAIT: buffered
    fork
      send_if(32'hDEAD_0000, 0, dc);   // slot full: dropped
      send_ex(rand_ex(), 0);           // ex owns the LSU: dropped
    join
    n0 = ready_cnt;
    wait_ready(n0);
    check("pending_issue_gap", last_ready_cyc - last_valid_cyc, 2);
    wait_idle();

    // stray lsu_valid in IDLE
    stray_cnt++;
    repeat (4) @(negedge clk);
    check("stray_busy", {31'd0, busy}, 32'd0);
    check("stray_ready", {31'd0, lsu_ready}, 32'd0);

    // reset while waiting, then a late lsu_valid
    resp_en = 0;
    n0 = ready_cnt;
    send_if(32'h3000_0200, 1, dc);
    wait_ready(n0);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    stray_cnt++;
    repeat (4) @(negedge clk);
    check("rst_wait_busy", {31'd0, busy}, 32'd0);
    check("rst_wait_ok", {30'd0, if_ok, ex_ok}, 32'd0);
    resp_en = 1;
    resp_fixed = -1;

    // randomized traffic from both requesters
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int w;
          d0 = if_done;
          send_if($urandom, 1, dc);
          for (w = 0; w < 300 && if_done == d0; w++) @(negedge clk);
          if (if_done == d0) begin
            check("if_done_timeout", if_done, d0 + 1);
            break;
          end
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
      begin
        for (int i = 0; i < 40; i++) begin
          int w, x0;
          x0 = ex_done;
          send_ex(rand_ex(), 1);
          for (w = 0; w < 300 && ex_done == x0; w++) @(negedge clk);
          if (ex_done == x0) begin
            check("ex_done_timeout", ex_done, x0 + 1);
            break;
          end
          repeat ($urandom_range(0, 2)) @(posedge clk);
        end
      end
    join
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // absolute guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
